// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and default widths for the pipeline hazard unit.
// Stage entries are {dst, tnew}; widths follow REG_AW/T_W.
package hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int T_W_DEF    = 2;
    localparam int FWD_SEL_W  = 2;

    // A Tuse of all-ones marks an operand the instruction never reads
    localparam int T_UNUSED = 3;

    localparam logic [FWD_SEL_W-1:0] FWD_RF = 2'd0;
    localparam logic [FWD_SEL_W-1:0] FWD_E  = 2'd1;
    localparam logic [FWD_SEL_W-1:0] FWD_M  = 2'd2;
    localparam logic [FWD_SEL_W-1:0] FWD_W  = 2'd3;

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// Per-operand hazard check: stall when the producer is not ready in time,
// otherwise pick the youngest stage that already holds the final value.
module hazard_cmp
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int T_W    = T_W_DEF
) (
    input  logic [REG_AW-1:0]    d_reg_i,
    input  logic [T_W-1:0]       d_tuse_i,
    input  logic [REG_AW-1:0]    e_dst_i,
    input  logic [T_W-1:0]       e_tnew_i,
    input  logic [REG_AW-1:0]    m_dst_i,
    input  logic [T_W-1:0]       m_tnew_i,
    input  logic [REG_AW-1:0]    w_dst_i,
    output logic                 stall_o,
    output logic [FWD_SEL_W-1:0] fwd_sel_o
);

    logic nz, used, e_hit, m_hit, w_hit;

    assign nz    = (d_reg_i != '0);
    assign used  = (d_tuse_i != T_W'(T_UNUSED));
    assign e_hit = nz & (e_dst_i == d_reg_i);
    assign m_hit = nz & (m_dst_i == d_reg_i);
    assign w_hit = nz & (w_dst_i == d_reg_i);

    assign stall_o = used & ((e_hit & (d_tuse_i < e_tnew_i)) |
                             (m_hit & (d_tuse_i < m_tnew_i)));

    // A younger match that is not ready yet shadows any older copy
    always_comb begin
        fwd_sel_o = FWD_RF;
        if (e_hit) begin
            if (e_tnew_i == '0) fwd_sel_o = FWD_E;
        end else if (m_hit) begin
            if (m_tnew_i == '0) fwd_sel_o = FWD_M;
        end else if (w_hit) begin
            fwd_sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage core: tracks E/M/W destinations and Tnew,
// drives stall, D-stage forwarding selects and the mult/div start pulse.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int T_W    = T_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_AW-1:0]    d_rs,
    input  logic [REG_AW-1:0]    d_rt,
    input  logic [T_W-1:0]       d_tuse_rs,
    input  logic [T_W-1:0]       d_tuse_rt,
    input  logic [REG_AW-1:0]    d_dst,
    input  logic [T_W-1:0]       d_tnew,
    input  logic                 d_md_use,
    input  logic                 d_md_start,
    input  logic                 md_busy,
    output logic                 stall,
    output logic                 md_start,
    output logic [FWD_SEL_W-1:0] fwd_rs_sel,
    output logic [FWD_SEL_W-1:0] fwd_rt_sel
);

    logic [REG_AW-1:0] e_dst_q, e_dst_d, m_dst_q, m_dst_d, w_dst_q, w_dst_d;
    logic [T_W-1:0]    e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
    logic              md_start_q, md_start_d;
    logic              stall_rs, stall_rt, stall_md;

    hazard_cmp #(.REG_AW(REG_AW), .T_W(T_W)) u_cmp_rs (
        .d_reg_i  (d_rs),
        .d_tuse_i (d_tuse_rs),
        .e_dst_i  (e_dst_q),
        .e_tnew_i (e_tnew_q),
        .m_dst_i  (m_dst_q),
        .m_tnew_i (m_tnew_q),
        .w_dst_i  (w_dst_q),
        .stall_o  (stall_rs),
        .fwd_sel_o(fwd_rs_sel)
    );

    hazard_cmp #(.REG_AW(REG_AW), .T_W(T_W)) u_cmp_rt (
        .d_reg_i  (d_rt),
        .d_tuse_i (d_tuse_rt),
        .e_dst_i  (e_dst_q),
        .e_tnew_i (e_tnew_q),
        .m_dst_i  (m_dst_q),
        .m_tnew_i (m_tnew_q),
        .w_dst_i  (w_dst_q),
        .stall_o  (stall_rt),
        .fwd_sel_o(fwd_rt_sel)
    );

    // md_start_q covers the cycle before the unit raises busy
    assign stall_md = d_md_use & (md_busy | md_start_q);
    // md_busy is external, so gate with reset to keep stall low throughout it
    assign stall    = reset & (stall_rs | stall_rt | stall_md);
    assign md_start = md_start_q;

    always_comb begin
        e_dst_d    = stall ? '0 : d_dst;
        e_tnew_d   = stall ? '0 : d_tnew;
        md_start_d = ~stall & d_md_start;
        m_dst_d    = e_dst_q;
        m_tnew_d   = (e_tnew_q == '0) ? '0 : e_tnew_q - T_W'(1);
        // Anything reaching W is final, so only its destination is kept
        w_dst_d    = m_dst_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_dst_q    <= '0;
            e_tnew_q   <= '0;
            m_dst_q    <= '0;
            m_tnew_q   <= '0;
            w_dst_q    <= '0;
            md_start_q <= 1'b0;
        end else begin
            e_dst_q    <= e_dst_d;
            e_tnew_q   <= e_tnew_d;
            m_dst_q    <= m_dst_d;
            m_tnew_q   <= m_tnew_d;
            w_dst_q    <= w_dst_d;
            md_start_q <= md_start_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl plus hand sequences for reset cases.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_use, d_md_start, md_busy;
    logic       stall, md_start;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int total = 0;
    int bad   = 0;

    hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_dst     (d_dst),
        .d_tnew    (d_tnew),
        .d_md_use  (d_md_use),
        .d_md_start(d_md_start),
        .md_busy   (md_busy),
        .stall     (stall),
        .md_start  (md_start),
        .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] trs, trt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       mu, ms, busy;
        logic       x_st, x_ms;
        logic [1:0] x_frs, x_frt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int rs, trs, rt, trt, dst, tnew, mu, ms, busy,
                                input int x_st, x_ms, x_frs, x_frt);
        vec_t v;
        v.rs = 5'(rs);   v.trs = 2'(trs); v.rt = 5'(rt); v.trt = 2'(trt);
        v.dst = 5'(dst); v.tnew = 2'(tnew);
        v.mu = 1'(mu);   v.ms = 1'(ms);   v.busy = 1'(busy);
        v.x_st = 1'(x_st); v.x_ms = 1'(x_ms); v.x_frs = 2'(x_frs); v.x_frt = 2'(x_frt);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic x_st, x_ms, input logic [1:0] x_frs, x_frt);
        chk({tag, " stall"}, {1'b0, stall}, {1'b0, x_st});
        chk({tag, " md_start"}, {1'b0, md_start}, {1'b0, x_ms});
        chk({tag, " fwd_rs"}, fwd_rs_sel, x_frs);
        chk({tag, " fwd_rt"}, fwd_rt_sel, x_frt);
    endtask

    task automatic drive(input vec_t v);
        d_rs = v.rs; d_tuse_rs = v.trs; d_rt = v.rt; d_tuse_rt = v.trt;
        d_dst = v.dst; d_tnew = v.tnew;
        d_md_use = v.mu; d_md_start = v.ms; md_busy = v.busy;
    endtask

    initial begin
        vec_t idle, mflo;
        idle = mk(0,3, 0,3, 0,0, 0,0,0, 0,0,0,0);
        mflo = mk(0,3, 0,3, 10,1, 1,0,0, 0,0,0,0);

        // Reset held with random inputs: outputs stay quiet
        reset = 1'b0;
        drive(idle);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            d_rs = 5'($urandom); d_rt = 5'($urandom); d_dst = 5'($urandom);
            d_tuse_rs = 2'($urandom); d_tuse_rt = 2'($urandom); d_tnew = 2'($urandom);
            d_md_use = 1'($urandom); d_md_start = 1'($urandom); md_busy = 1'($urandom);
            #1 chk_all($sformatf("rst%0d", i), 0, 0, 0, 0);
        end
        drive(idle);
        #2 reset = 1'b1;
        #1 chk_all("rel", 0, 0, 0, 0);
        @(posedge clk); #1;

        //           rs trs rt trt dst tn mu ms bz | st ms frs frt
        vq.push_back(mk(29,1, 0,3,  8,2, 0,0,0,  0,0,0,0)); // lw $8
        vq.push_back(mk( 8,1,10,1,  9,1, 0,0,0,  1,0,0,0)); // add: load in E
        vq.push_back(mk( 8,1,10,1,  9,1, 0,0,0,  0,0,0,0)); // load in M, tnew 1
        vq.push_back(mk( 8,1, 9,1, 11,1, 0,0,0,  0,0,3,0)); // $8 from W, $9 in E tnew 1
        vq.push_back(mk( 9,0,11,0,  0,0, 0,0,0,  1,0,2,0)); // tuse 0 vs E tnew 1
        vq.push_back(mk( 9,0,11,0,  0,0, 0,0,0,  0,0,3,2));
        vq.push_back(mk(29,1, 0,3,  0,2, 0,0,0,  0,0,0,0)); // lw $0
        vq.push_back(mk( 0,0, 0,0,  3,1, 0,0,0,  0,0,0,0)); // reads $0
        vq.push_back(mk( 0,3, 0,3,  5,0, 0,0,0,  0,0,0,0));
        vq.push_back(mk( 3,0, 0,3,  5,0, 0,0,0,  0,0,2,0));
        vq.push_back(mk( 5,0, 3,0,  6,1, 0,0,0,  0,0,1,3)); // $5 in E and M -> E
        vq.push_back(mk( 5,1, 6,2,  0,0, 0,0,0,  0,0,2,0)); // E=$6 tnew1, M=$5 tnew0
        vq.push_back(mk( 0,3, 0,3,  5,0, 0,0,0,  0,0,0,0));
        vq.push_back(mk( 0,3, 0,3,  5,1, 0,0,0,  0,0,0,0));
        vq.push_back(mk( 5,2, 5,1,  0,0, 0,0,0,  0,0,0,0)); // E $5 tnew1 shadows M
        vq.push_back(mk( 5,0, 5,3,  0,0, 0,0,0,  0,0,2,2));
        vq.push_back(mk( 8,0, 9,0,  0,0, 1,1,0,  0,0,0,0)); // mult
        vq.push_back(mflo);
        vq[$].x_st = 1; vq[$].x_ms = 1;
        for (int i = 0; i < 5; i++) begin
            vq.push_back(mflo);
            vq[$].busy = 1; vq[$].x_st = 1;
        end
        vq.push_back(mflo);                                 // busy fell: mflo issues
        vq.push_back(mk(10,0, 0,3,  0,0, 1,1,1,  1,0,0,0)); // mult while busy + reg stall
        vq.push_back(mk(10,0, 0,3,  0,0, 1,1,0,  0,0,2,0));
        vq.push_back(mk( 0,3, 0,3,  0,0, 0,0,0,  0,1,0,0));
        vq.push_back(idle);

        foreach (vq[i]) begin
            drive(vq[i]);
            #1 chk_all($sformatf("v%0d", i), vq[i].x_st, vq[i].x_ms, vq[i].x_frs, vq[i].x_frt);
            @(posedge clk); #1;
        end

        // Reset during an MD stall
        drive(mk(0,3, 0,3, 0,0, 1,1,0, 0,0,0,0));
        #1 chk_all("r6 mult", 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(mflo);
        #1 chk_all("r6 mflo", 1, 1, 0, 0);
        @(posedge clk); #1;
        md_busy = 1'b1;
        #1 chk_all("r6 busy", 1, 0, 0, 0);
        #1 reset = 1'b0;
        #1 chk_all("r6 async", 0, 0, 0, 0);
        @(posedge clk); #1 chk_all("r6 held", 0, 0, 0, 0);
        md_busy = 1'b0;
        #2 reset = 1'b1;
        #1 chk_all("r6 rel", 0, 0, 0, 0);
        @(posedge clk); #1 chk_all("r6 after", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
